conv_encoder_8bit: RTL and testbench
====================================

CONV_ENCODER_8BIT -- requirements
Module: conv_encoder_8bit

Interface
REQ-001 Parameter: DATA_W, default 8, number of information bits per block; code width is 2*DATA_W.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to encode data_in; sampled only in IDLE.
REQ-005 data_in  input  DATA_W  information word; bit 0 is encoded first.
REQ-006 code_out  output  2*DATA_W  block codeword; pair k occupies bits [2k+1:2k].
REQ-007 pair_out  output  2  serial code pair for the bit just encoded.
REQ-008 pair_valid  output  1  pair_out valid this cycle.
REQ-009 busy  output  1  high while in ENC.
REQ-010 done  output  1  one-cycle pulse when code_out is complete.

Function
REQ-011 Code: rate 1/2, constraint length 3, zero-start trellis, generators 101 (high bit) and 111 (low bit), matching the 4-state downstream Viterbi decoder.
REQ-012 For bit k with u_k = data bit, u_{k-1}, u_{k-2} = previous bits (0 before bit 0): pair[1] = u_k ^ u_{k-2}; pair[0] = u_k ^ u_{k-1} ^ u_{k-2}.
REQ-013 FSM states IDLE, ENC; IDLE->ENC on the edge sampling start=1; ENC->IDLE on the edge encoding bit DATA_W-1.
REQ-014 On the start edge: data_in captured into a shift register, shift state {u_{k-1},u_{k-2}} cleared to 0, bit counter cleared to 0, code_out cleared to 0.
REQ-015 Each ENC edge encodes one bit: writes code_out[2k+1:2k], registers pair_out, advances shift state and counter.
REQ-016 pair_valid high for exactly DATA_W consecutive cycles, the cycles following each ENC edge.
REQ-017 Latency: start sampled at edge 0 -> pair k valid after edge k+1 -> done high after edge DATA_W, coincident with the final pair_valid.
REQ-018 code_out holds its value from done until the next accepted start; data_in changes after the start edge have no effect.
REQ-019 start while busy is ignored (no restart, no queueing); start held high continuously re-triggers in the cycle after done.
REQ-020 busy = (state == ENC); done and pair_valid are registered outputs.

Reset
REQ-021 reset=1 on an edge forces IDLE; code_out=0, pair_out=0, pair_valid=0, busy=0, done=0, counter=0, shift state=0.
REQ-022 reset has priority over start; reset mid-ENC aborts the block with no done pulse.

Configuration
REQ-023 Macro CONV_ENC_ERR_INJECT_EN: when defined, adds input err_mask[2*DATA_W-1:0], captured on the start edge, XORed into each pair as written to code_out and pair_out (shift state unaffected).
REQ-024 Without CONV_ENC_ERR_INJECT_EN, no err_mask port exists and output is the clean codeword.

Structure
REQ-025 Shared package holds DATA_W default, FSM state encoding, and generator constants G_HI=3'b101, G_LO=3'b111, shared with the decoder.
REQ-026 One sub-module conv_enc_core: combinational pair = f(u_k, shift state, generators); FSM, counter and registers stay in the top.

Verification
REQ-027 data_in=0x00, start pulse -> code_out=0x0000, done one cycle after edge 8, pair_valid 8 cycles.
REQ-028 data_in=0x01 -> code_out=0x0037; pair_out sequence 11,01,11,00,00,00,00,00.
REQ-029 data_in=0xFF -> code_out=0x555B; done pulse exactly one cycle, busy low thereafter.
REQ-030 start re-pulsed at ENC cycle 3 with new data_in -> ignored, code_out matches original word, single done.
REQ-031 reset asserted at ENC cycle 4 -> next cycle all outputs 0, no done; subsequent start with 0x01 yields 0x0037.
REQ-032 CONV_ENC_ERR_INJECT_EN defined, data_in=0x01, err_mask=0x0001 -> code_out=0x0036; loopback to decoder yields data_out=0x01.

Source files
------------

// File: rtl/conv_encoder_8bit_pkg.sv
// Shared constants for the rate-1/2, K=3 convolutional encoder and its matching Viterbi decoder.
// Generator taps are ordered {u_k, u_k-1, u_k-2}.
package conv_encoder_8bit_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] G_HI = 3'b101;
    localparam logic [2:0] G_LO = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ENC  = 1'b1
    } enc_state_e;

    function automatic logic gen_parity(input logic [2:0] taps, input logic [2:0] gen);
        return ^(taps & gen);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis branch: one input bit plus the two-bit shift state gives one code pair.
// pair[1] comes from the G_HI generator, pair[0] from G_LO.
module conv_enc_core
    import conv_encoder_8bit_pkg::*;
(
    input  logic       i_u,
    input  logic [1:0] i_shift,
    output logic [1:0] o_pair
);

    logic [2:0] w_taps;

    assign w_taps    = {i_u, i_shift};
    assign o_pair[1] = gen_parity(w_taps, G_HI);
    assign o_pair[0] = gen_parity(w_taps, G_LO);

endmodule

// File: rtl/conv_encoder_8bit.sv
// Block convolutional encoder: captures a DATA_W word on start and emits one code pair per cycle.
// Optional error injection is enabled with the CONV_ENC_ERR_INJECT_EN macro (adds i_err_mask).
module conv_encoder_8bit
    import conv_encoder_8bit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_data_in,
`ifdef CONV_ENC_ERR_INJECT_EN
    input  logic [2*DATA_W-1:0]   i_err_mask,
`endif
    output logic [2*DATA_W-1:0]   o_code_out,
    output logic [1:0]            o_pair_out,
    output logic                  o_pair_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    enc_state_e            r_state;
    logic [DATA_W-1:0]     r_data;
    logic [1:0]            r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_code;
    logic [1:0]            r_pair;
    logic                  r_pair_valid;
    logic                  r_done;
    logic [1:0]            w_pair_clean;
    logic [1:0]            w_pair;

    conv_enc_core u_core (
        .i_u     (r_data[0]),
        .i_shift (r_shift),
        .o_pair  (w_pair_clean)
    );

`ifdef CONV_ENC_ERR_INJECT_EN
    logic [2*DATA_W-1:0]   r_err;

    // Error mask shifts alongside the data so its low pair lines up with the current bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_err <= i_err_mask;
            end else begin
                r_err <= r_err;
            end
        end else begin
            r_err <= r_err >> 2;
        end
    end

    assign w_pair = w_pair_clean ^ r_err[1:0];
`else
    assign w_pair = w_pair_clean;
`endif

    // Block FSM: bit k is encoded on ENC edge k+1; the last edge raises done and returns to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_shift      <= 2'b00;
            r_cnt        <= '0;
            r_code       <= '0;
            r_pair       <= 2'b00;
            r_pair_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pair_valid <= 1'b0;
                    r_done       <= 1'b0;
                    if (i_start) begin
                        r_state <= ST_ENC;
                        r_data  <= i_data_in;
                        r_shift <= 2'b00;
                        r_cnt   <= '0;
                        r_code  <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ENC: begin
                    r_code[{r_cnt, 1'b0} +: 2] <= w_pair;
                    r_pair       <= w_pair;
                    r_pair_valid <= 1'b1;
                    r_shift      <= {r_data[0], r_shift[1]};
                    r_data       <= r_data >> 1;
                    r_cnt        <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_ENC;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pair_valid <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign o_code_out   = r_code;
    assign o_pair_out   = r_pair;
    assign o_pair_valid = r_pair_valid;
    assign o_busy       = (r_state == ST_ENC);
    assign o_done       = r_done;

endmodule

// File: tb/tb_conv_encoder_8bit.sv
// Scoreboard bench for conv_encoder_8bit: a bit-level arithmetic model queues expected pairs and
// codewords; an independent monitor pops and compares whenever the DUT presents output.
module tb_conv_encoder_8bit;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [W-1:0]      data_in;
    logic [2*W-1:0]    code_out;
    logic [1:0]        pair_out;
    logic              pair_valid;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    conv_encoder_8bit #(.DATA_W(W)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_data_in    (data_in),
`ifdef CONV_ENC_ERR_INJECT_EN
        .i_err_mask   ('0),
`endif
        .o_code_out   (code_out),
        .o_pair_out   (pair_out),
        .o_pair_valid (pair_valid),
        .o_busy       (busy),
        .o_done       (done)
    );

    logic [1:0]     q_pair[$];
    logic [2*W-1:0] q_code[$];
    logic [2*W-1:0] last_exp;
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int done_cnt = 0;
    int pv_cnt = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each pair is the mod-2 sum of the selected input bits, bits before 0 are zero.
    task automatic model_push(input logic [W-1:0] d);
        int u[W+2];
        int p1, p0;
        logic [2*W-1:0] code;
        code = '0;
        u[0] = 0;
        u[1] = 0;
        for (int k = 0; k < W; k++) u[k+2] = (int'(d) >> k) & 1;
        for (int k = 0; k < W; k++) begin
            p1 = (u[k+2] + u[k]) % 2;
            p0 = (u[k+2] + u[k+1] + u[k]) % 2;
            q_pair.push_back(2'(p1 * 2 + p0));
            code = code | ((2*W)'(p1 * 2 + p0) << (2 * k));
        end
        q_code.push_back(code);
        last_exp = code;
    endtask

    // Monitor: compare whatever the DUT presents against the head of the queues.
    initial begin
        logic [1:0]     ep;
        logic [2*W-1:0] ec;
        forever begin
            @(posedge clk);
            #1;
            if (pair_valid) begin
                pv_cnt++;
                chk("pair_expected", 32'(q_pair.size() > 0), 32'd1);
                if (q_pair.size() > 0) begin
                    ep = q_pair.pop_front();
                    chk("pair_out", 32'(pair_out), 32'(ep));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_with_last_pair", 32'(pair_valid), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("code_expected", 32'(q_code.size() > 0), 32'd1);
                if (q_code.size() > 0) begin
                    ec = q_code.pop_front();
                    chk("code_out", 32'(code_out), 32'(ec));
                end
            end
        end
    end

    task automatic run_block(input logic [W-1:0] d, input int repulse);
        int d0, p0, st;
        @(negedge clk);
        model_push(d);
        data_in = d;
        start   = 1'b1;
        d0 = done_cnt;
        p0 = pv_cnt;
        @(posedge clk);
        #1;
        st = cyc;
        @(negedge clk);
        start   = 1'b0;
        data_in = W'($urandom);
        for (int i = 1; i < 40 && done_cnt == d0; i++) begin
            if (i == repulse) begin
                start   = 1'b1;
                data_in = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("done_latency", 32'(done_cyc - st), 32'(W));
        chk("pair_valid_count", 32'(pv_cnt - p0), 32'(W));
        repeat (3) @(negedge clk);
        chk("code_hold", 32'(code_out), 32'(last_exp));
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0, st;
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_code", 32'(code_out), 32'd0);
        chk("rst_pair", 32'(pair_out), 32'd0);
        chk("rst_pv", 32'(pair_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_block(8'h00, 0);
        run_block(8'h01, 0);
        chk("code_0x01", 32'(code_out), 32'h0037);
        run_block(8'hFF, 0);
        chk("code_0xFF", 32'(code_out), 32'h555B);
        run_block(8'hA5, 3);

        // Reset four cycles into a block: all outputs clear and no done follows.
        @(negedge clk);
        model_push(8'h5A);
        data_in = 8'h5A;
        start   = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_code", 32'(code_out), 32'd0);
        chk("abort_pair", 32'(pair_out), 32'd0);
        chk("abort_pv", 32'(pair_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        q_pair.delete();
        q_code.delete();
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_block(8'h01, 0);
        chk("code_after_abort", 32'(code_out), 32'h0037);

        // Start held high: second block begins on the edge after done.
        @(negedge clk);
        model_push(8'h3C);
        data_in = 8'h3C;
        start   = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        st = cyc;
        @(negedge clk);
        data_in = 8'hC9;
        model_push(8'hC9);
        for (int i = 0; i < 60 && done_cnt < d0 + 2; i++) @(negedge clk);
        start = 1'b0;
        chk("held_two_dones", 32'(done_cnt - d0), 32'd2);
        chk("held_latency", 32'(done_cyc - st), 32'(2 * W + 1));
        repeat (4) @(negedge clk);
        chk("held_stop", 32'(done_cnt - d0), 32'd2);
        chk("held_busy", 32'(busy), 32'd0);

        repeat (20) run_block(W'($urandom), int'($urandom_range(0, W - 1)));

        chk("queues_drained", 32'(q_pair.size() + q_code.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
